// File: rtl/brs_pkg.sv
// Shared types and default widths for the BRS rate meter.
// Optional build macro used by this block: BRS_METER_SYNC_EN.
package brs_pkg;

    localparam int CNT_W_DEF  = 16;
    localparam int GATE_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/brs_rate_meter_if.sv
// Host-side bus of the rate meter: measurement request plus result handshake.
// Handshake: result_valid stays high, with result/overflow stable, until a cycle
// where result_ready is also high; that cycle transfers the result. start is a
// request, not a handshake: it is only honoured while busy is low.
interface brs_rate_meter_if
    import brs_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int GATE_W = GATE_W_DEF
);
    logic              start;
    logic [GATE_W-1:0] gate_len;
    logic              busy;
    logic [CNT_W-1:0]  result;
    logic              overflow;
    logic              result_valid;
    logic              result_ready;

    modport master (
        output start, gate_len, result_ready,
        input  busy, result, overflow, result_valid
    );

    modport slave (
        input  start, gate_len, result_ready,
        output busy, result, overflow, result_valid
    );

endinterface

// File: rtl/brs_edge_detect.sv
// Rising-edge detector for the BRS pulse; BRS_METER_SYNC_EN adds a 2-flop
// synchronizer in front of the history flop.
module brs_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic pulse_in,
    output logic rise
);

`ifdef BRS_METER_SYNC_EN
    logic [1:0] sync_q;
    logic       hist_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b00;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], pulse_in};
            hist_q <= sync_q[1];
        end
    end

    assign rise = sync_q[1] & ~hist_q;
`else
    logic hist_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= 1'b0;
        end else begin
            hist_q <= pulse_in;
        end
    end

    assign rise = pulse_in & ~hist_q;
`endif

endmodule

// File: rtl/brs_rate_meter.sv
// Counts rising edges of the BRS pulse over a gate window of N clk cycles and
// holds the count for a valid/ready readout. Build option: BRS_METER_SYNC_EN.
module brs_rate_meter
    import brs_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int GATE_W = GATE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pulse_in,
    brs_rate_meter_if.slave   bus,
    output state_t            state_dbg
);

    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [GATE_W-1:0] GATE_ONE = GATE_W'(1);

    state_t            state, state_nxt;
    logic [GATE_W-1:0] win_q, win_nxt;
    logic [CNT_W-1:0]  cnt_q, cnt_nxt;
    logic [CNT_W-1:0]  res_q, res_nxt;
    logic              ovf_q, ovf_nxt;
    logic              rise;
    logic              cnt_max;
    logic [CNT_W-1:0]  cnt_sat;

    brs_edge_detect u_edge (
        .clk      (clk),
        .rst      (rst),
        .pulse_in (pulse_in),
        .rise     (rise)
    );

    assign cnt_max = &cnt_q;
    assign cnt_sat = cnt_max ? cnt_q : cnt_q + CNT_ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            win_q <= '0;
            cnt_q <= '0;
            res_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            state <= state_nxt;
            win_q <= win_nxt;
            cnt_q <= cnt_nxt;
            res_q <= res_nxt;
            ovf_q <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        win_nxt   = win_q;
        cnt_nxt   = cnt_q;
        res_nxt   = res_q;
        ovf_nxt   = ovf_q;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    cnt_nxt = '0;
                    ovf_nxt = 1'b0;
                    if (bus.gate_len == '0) begin
                        state_nxt = HOLD;
                        res_nxt   = '0;
                    end else begin
                        state_nxt = GATE;
                        win_nxt   = bus.gate_len;
                    end
                end
            end
            GATE: begin
                if (rise) begin
                    cnt_nxt = cnt_sat;
                    ovf_nxt = ovf_q | cnt_max;
                end
                // Last gated cycle: its own event must land in the result.
                if (win_q == GATE_ONE) begin
                    state_nxt = HOLD;
                    res_nxt   = rise ? cnt_sat : cnt_q;
                end else begin
                    win_nxt = win_q - GATE_ONE;
                end
            end
            HOLD: begin
                if (bus.result_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.busy         = (state != IDLE);
    assign bus.result_valid = (state == HOLD);
    assign bus.result       = res_q;
    assign bus.overflow     = ovf_q;
    assign state_dbg        = state;

endmodule

// File: tb/tb_brs_rate_meter.sv
// Directed bench for brs_rate_meter: a 16-bit and a 4-bit counter instance share
// the same stimulus so saturation can be seen next to the unsaturated count.
module tb_brs_rate_meter;
    import brs_pkg::*;

    logic        clk;
    logic        rst;
    logic        pulse_in;
    logic        start;
    logic [15:0] gate_len;
    logic        result_ready;
    state_t      state16;
    state_t      state4;

    int checks;
    int failures;
    logic [31:0] exp_q[$];

    brs_rate_meter_if #(.CNT_W(16), .GATE_W(16)) bus16 ();
    brs_rate_meter_if #(.CNT_W(4),  .GATE_W(16)) bus4 ();

    assign bus16.start        = start;
    assign bus16.gate_len     = gate_len;
    assign bus16.result_ready = result_ready;
    assign bus4.start         = start;
    assign bus4.gate_len      = gate_len;
    assign bus4.result_ready  = result_ready;

    brs_rate_meter #(.CNT_W(16), .GATE_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .pulse_in  (pulse_in),
        .bus       (bus16),
        .state_dbg (state16)
    );

    brs_rate_meter #(.CNT_W(4), .GATE_W(16)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .pulse_in  (pulse_in),
        .bus       (bus4),
        .state_dbg (state4)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Pulse level for gated cycle t+k: 0 alternate from 1, 1 held high, 2 low.
    function automatic logic pat(input int mode, input int k);
        case (mode)
            0:       return logic'(k % 2);
            1:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Start a window of n cycles, check valid latency and the final counts.
    task automatic do_window(input int n, input int mode, input int exp16,
                             input int exp4, input logic exp_ovf4);
        int lat;
        pulse_in = 1'b0;
        start    = 1'b1;
        gate_len = 16'(n);
        @(negedge clk);
        start    = 1'b0;
        gate_len = 16'($urandom_range(1, 65535));
        lat      = 0;
        for (int k = 1; k <= n + 4 && !bus16.result_valid; k++) begin
            pulse_in = pat(mode, k);
            @(negedge clk);
            lat = k;
        end
        check_eq("latency", lat, n);
        exp_q.push_back(32'(exp16));
        exp_q.push_back(32'(exp4));
        check_eq("result16", 32'(bus16.result), exp_q.pop_front());
        check_eq("result4", 32'(bus4.result), exp_q.pop_front());
        check_eq("overflow16", 32'(bus16.overflow), 32'd0);
        check_eq("overflow4", 32'(bus4.overflow), 32'(exp_ovf4));
        check_eq("state_hold", 32'(state16), 32'(HOLD));
    endtask

    task automatic release_result(input int exp16);
        pulse_in     = 1'b0;
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        check_eq("valid_after_ready", 32'(bus16.result_valid), 32'd0);
        check_eq("busy_after_ready", 32'(bus16.busy), 32'd0);
        check_eq("result_retained", 32'(bus16.result), 32'(exp16));
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        pulse_in     = 1'b0;
        start        = 1'b0;
        gate_len     = '0;
        result_ready = 1'b0;

        // Reset with random inputs
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            pulse_in     = logic'($urandom_range(0, 1));
            start        = logic'($urandom_range(0, 1));
            gate_len     = 16'($urandom_range(0, 65535));
            result_ready = logic'($urandom_range(0, 1));
        end
        @(negedge clk);
        check_eq("rst_busy", 32'(bus16.busy), 32'd0);
        check_eq("rst_valid", 32'(bus16.result_valid), 32'd0);
        check_eq("rst_result", 32'(bus16.result), 32'd0);
        check_eq("rst_overflow", 32'(bus16.overflow), 32'd0);
        check_eq("rst_state", 32'(state16), 32'(IDLE));
        rst          = 1'b0;
        pulse_in     = 1'b0;
        start        = 1'b0;
        result_ready = 1'b0;
        @(negedge clk);
        check_eq("idle_busy", 32'(bus16.busy), 32'd0);

        // N=10 alternating -> 5 events
        do_window(10, 0, 5, 5, 1'b0);
        release_result(5);

        // N=0 -> immediate zero result
        do_window(0, 0, 0, 0, 1'b0);
        release_result(0);

        // Level held high counts once
        do_window(8, 1, 1, 1, 1'b0);
        release_result(1);

        // No pulses -> zero
        do_window(5, 2, 0, 0, 1'b0);
        release_result(0);

        // N=40 alternating: 20 events, 4-bit instance saturates
        do_window(40, 0, 20, 15, 1'b1);

        // HOLD stall with start pulses ignored
        for (int i = 0; i < 5; i++) begin
            start    = logic'(i % 2 == 0);
            gate_len = 16'd3;
            @(negedge clk);
            check_eq("stall_valid", 32'(bus16.result_valid), 32'd1);
            check_eq("stall_result", 32'(bus16.result), 32'd20);
            check_eq("stall_result4", 32'(bus4.result), 32'd15);
        end
        start = 1'b0;
        release_result(20);
        check_eq("ovf4_sticky", 32'(bus4.overflow), 32'd1);
        check_eq("idle_state", 32'(state16), 32'(IDLE));

        // Reset in the middle of a gate window
        pulse_in = 1'b0;
        start    = 1'b1;
        gate_len = 16'd10;
        @(negedge clk);
        start = 1'b0;
        check_eq("start_busy", 32'(bus16.busy), 32'd1);
        check_eq("start_clears_ovf4", 32'(bus4.overflow), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            pulse_in = pat(0, k);
            @(negedge clk);
        end
        rst      = 1'b1;
        pulse_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_busy", 32'(bus16.busy), 32'd0);
        check_eq("midrst_state", 32'(state16), 32'(IDLE));
        check_eq("midrst_result", 32'(bus16.result), 32'd0);
        check_eq("midrst_valid", 32'(bus16.result_valid), 32'd0);
        do_window(6, 0, 3, 3, 1'b0);
        release_result(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
